alp_step_seq: RTL and testbench

//  Sequencer for the ALP A/B operand muxes during iterative multiply, divide and shift operations.
//  It accepts a start request, then drives a registered mux_h/ext_ena_h code each cycle into the ALP slice mux decode.
//  It runs a load cycle, then N step cycles, then an optional divide fix-up cycle, and signals completion.
//  It sits between the microsequencer step request and the ALP slices. All outputs are registered.

---
 rtl/alp_step_seq.sv | 164 ++++++++++++++++
 tb/tb_alp_step_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alp_step_seq.sv
// ALP A/B operand-mux sequencer: LOAD, N x STEP, optional DIV FIX, DONE; all outputs registered.
// Optional feature macro: ALP_SEQ_EXT_PAD_EN (drives ext_ena_h high in MUL STEP cycles).
module alp_step_seq #(
    parameter int         CNT_W    = 6,
    parameter logic [3:0] IDLE_MUX = 4'b0000
) (
    input  logic             clk_h,
    input  logic             reset_h,
    input  logic             start_h,
    input  logic [1:0]       op_h,
    input  logic [CNT_W-1:0] count_h,
    input  logic             stall_h,
    output logic             busy_h,
    output logic             done_h,
    output logic [3:0]       mux_h,
    output logic             ext_ena_h,
    output logic             qshift_en_h,
    output logic [CNT_W-1:0] step_cnt_h
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_FIX,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_DIV   = 2'b01,
        OP_SHIFT = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    localparam logic [3:0] MUX_LOAD  = 4'b1000;
    localparam logic [3:0] MUX_MUL   = 4'b0110;
    localparam logic [3:0] MUX_DIV   = 4'b1110;
    localparam logic [3:0] MUX_SHIFT = 4'b1111;
    localparam logic [3:0] MUX_FIX   = 4'b1100;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       mux_q, mux_d;
    logic             qsh_q, qsh_d;
    logic             hold;

    // Stall only freezes an operation in flight; IDLE keeps accepting starts.
    assign hold = stall_h && (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_h) begin
                    state_d = S_LOAD;
                    op_d    = op_t'(op_h);
                    cnt_d   = (op_t'(op_h) == OP_RSVD) ? '0 : count_h;
                end
            end
            S_LOAD: begin
                if (!hold) begin
                    if (op_q == OP_RSVD) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else if (cnt_q != '0) begin
                        state_d = S_STEP;
                    end else if (op_q == OP_DIV) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_STEP: begin
                if (!hold) begin
                    // Last step: counter lands on zero and never wraps below it.
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = (op_q == OP_DIV) ? S_FIX : S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_FIX: begin
                if (!hold) state_d = S_DONE;
            end
            S_DONE: begin
                if (!hold) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet line up with it.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        qsh_d  = (state_d == S_STEP) && !hold;
        mux_d  = IDLE_MUX;
        case (state_d)
            S_LOAD: mux_d = MUX_LOAD;
            S_STEP: begin
                case (op_d)
                    OP_MUL:   mux_d = MUX_MUL;
                    OP_DIV:   mux_d = MUX_DIV;
                    OP_SHIFT: mux_d = MUX_SHIFT;
                    default:  mux_d = IDLE_MUX;
                endcase
            end
            S_FIX:   mux_d = MUX_FIX;
            default: mux_d = IDLE_MUX;
        endcase
    end

    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            state_q <= S_IDLE;
            op_q    <= OP_MUL;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mux_q   <= IDLE_MUX;
            qsh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mux_q   <= mux_d;
            qsh_q   <= qsh_d;
        end
    end

`ifdef ALP_SEQ_EXT_PAD_EN
    logic ext_q, ext_d;

    // Pad select rides on the MUL step code 0110 (P->A instead of M->A).
    assign ext_d = (state_d == S_STEP) && (op_d == OP_MUL);

    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) ext_q <= 1'b0;
        else         ext_q <= ext_d;
    end

    assign ext_ena_h = ext_q;
`else
    assign ext_ena_h = 1'b0;
`endif

    assign busy_h      = busy_q;
    assign done_h      = done_q;
    assign mux_h       = mux_q;
    assign qshift_en_h = qsh_q;
    assign step_cnt_h  = cnt_q;

endmodule

// File: tb/tb_alp_step_seq.sv
// Directed bench for alp_step_seq: per-cycle expected outputs go through a scoreboard queue.
module tb_alp_step_seq;

    localparam int CNT_W = 6;
    localparam int VW    = CNT_W + 8;

    localparam logic [3:0] M_IDL = 4'h0;
    localparam logic [3:0] M_LD  = 4'h8;
    localparam logic [3:0] M_MUL = 4'h6;
    localparam logic [3:0] M_DIV = 4'hE;
    localparam logic [3:0] M_SHF = 4'hF;
    localparam logic [3:0] M_FIX = 4'hC;

    logic             clk_h = 1'b0;
    logic             reset_h, start_h, stall_h;
    logic [1:0]       op_h;
    logic [CNT_W-1:0] count_h;
    logic             busy_h, done_h, ext_ena_h, qshift_en_h;
    logic [3:0]       mux_h;
    logic [CNT_W-1:0] step_cnt_h;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string          tag;
        logic [VW-1:0]  v;
    } exp_t;

    exp_t sb[$];

    always #5 clk_h = ~clk_h;

    alp_step_seq #(.CNT_W(CNT_W), .IDLE_MUX(4'b0000)) dut (
        .clk_h      (clk_h),
        .reset_h    (reset_h),
        .start_h    (start_h),
        .op_h       (op_h),
        .count_h    (count_h),
        .stall_h    (stall_h),
        .busy_h     (busy_h),
        .done_h     (done_h),
        .mux_h      (mux_h),
        .ext_ena_h  (ext_ena_h),
        .qshift_en_h(qshift_en_h),
        .step_cnt_h (step_cnt_h)
    );

    // mstep marks a MUL STEP cycle: ext_ena_h is expected high there only with the pad feature.
    task automatic push(input string tag, input logic b, input logic d, input logic [3:0] mux,
                        input logic mstep, input logic qs, input logic [CNT_W-1:0] cnt);
        exp_t e;
        logic ext;
`ifdef ALP_SEQ_EXT_PAD_EN
        ext = mstep;
`else
        ext = 1'b0;
`endif
        e.tag = tag;
        e.v   = {b, d, mux, ext, qs, cnt};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t          e;
        logic [VW-1:0] obs;
        obs = {busy_h, done_h, mux_h, ext_ena_h, qshift_en_h, step_cnt_h};
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $error("FAIL sb_empty: observed %h, expected an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                tests_failed++;
                $error("FAIL %s: observed busy/done/mux/ext/qs/cnt=%h, expected %h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic cyc(input string tag, input logic b, input logic d, input logic [3:0] mux,
                       input logic mstep, input logic qs, input logic [CNT_W-1:0] cnt);
        push(tag, b, d, mux, mstep, qs, cnt);
        @(posedge clk_h);
        #1;
        check();
    endtask

    task automatic go(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
        start_h = 1'b1;
        op_h    = op;
        count_h = cnt;
    endtask

    // Drop start and scramble op/count so any non-latched use shows up.
    task automatic release_start();
        start_h = 1'b0;
        op_h    = 2'b10;
        count_h = '1;
    endtask

    initial begin
        reset_h = 1'b1;
        start_h = 1'b0;
        stall_h = 1'b0;
        op_h    = 2'b00;
        count_h = '0;
        #2;
        push("reset", 0, 0, M_IDL, 0, 0, 0);
        check();
        @(posedge clk_h);
        #1;
        push("reset_held", 0, 0, M_IDL, 0, 0, 0);
        check();
        reset_h = 1'b0;
        cyc("idle", 0, 0, M_IDL, 0, 0, 0);

        // MUL count 4
        go(2'b00, 6'd4);
        cyc("mul4_load", 1, 0, M_LD, 0, 0, 4);
        release_start();
        cyc("mul4_s4", 1, 0, M_MUL, 1, 1, 4);
        cyc("mul4_s3", 1, 0, M_MUL, 1, 1, 3);
        cyc("mul4_s2", 1, 0, M_MUL, 1, 1, 2);
        cyc("mul4_s1", 1, 0, M_MUL, 1, 1, 1);
        cyc("mul4_done", 1, 1, M_IDL, 0, 0, 0);
        cyc("mul4_idle", 0, 0, M_IDL, 0, 0, 0);

        // DIV count 3
        go(2'b01, 6'd3);
        cyc("div3_load", 1, 0, M_LD, 0, 0, 3);
        release_start();
        cyc("div3_s3", 1, 0, M_DIV, 0, 1, 3);
        cyc("div3_s2", 1, 0, M_DIV, 0, 1, 2);
        cyc("div3_s1", 1, 0, M_DIV, 0, 1, 1);
        cyc("div3_fix", 1, 0, M_FIX, 0, 0, 0);
        cyc("div3_done", 1, 1, M_IDL, 0, 0, 0);
        cyc("div3_idle", 0, 0, M_IDL, 0, 0, 0);

        // SHIFT count 0, reserved op, DIV count 0
        go(2'b10, 6'd0);
        cyc("shf0_load", 1, 0, M_LD, 0, 0, 0);
        release_start();
        cyc("shf0_done", 1, 1, M_IDL, 0, 0, 0);
        cyc("shf0_idle", 0, 0, M_IDL, 0, 0, 0);
        go(2'b11, 6'd9);
        cyc("rsv_load", 1, 0, M_LD, 0, 0, 0);
        release_start();
        cyc("rsv_done", 1, 1, M_IDL, 0, 0, 0);
        cyc("rsv_idle", 0, 0, M_IDL, 0, 0, 0);
        go(2'b01, 6'd0);
        cyc("div0_load", 1, 0, M_LD, 0, 0, 0);
        release_start();
        cyc("div0_fix", 1, 0, M_FIX, 0, 0, 0);
        cyc("div0_done", 1, 1, M_IDL, 0, 0, 0);
        cyc("div0_idle", 0, 0, M_IDL, 0, 0, 0);

        // MUL count 5 with a 3-cycle stall mid-STEP and a start pulse while busy
        go(2'b00, 6'd5);
        cyc("mul5_load", 1, 0, M_LD, 0, 0, 5);
        release_start();
        cyc("mul5_s5", 1, 0, M_MUL, 1, 1, 5);
        cyc("mul5_s4", 1, 0, M_MUL, 1, 1, 4);
        stall_h = 1'b1;
        cyc("mul5_stall1", 1, 0, M_MUL, 1, 0, 4);
        go(2'b01, 6'd2);
        cyc("mul5_stall2", 1, 0, M_MUL, 1, 0, 4);
        release_start();
        cyc("mul5_stall3", 1, 0, M_MUL, 1, 0, 4);
        stall_h = 1'b0;
        cyc("mul5_s3", 1, 0, M_MUL, 1, 1, 3);
        cyc("mul5_s2", 1, 0, M_MUL, 1, 1, 2);
        cyc("mul5_s1", 1, 0, M_MUL, 1, 1, 1);
        cyc("mul5_done", 1, 1, M_IDL, 0, 0, 0);
        cyc("mul5_idle", 0, 0, M_IDL, 0, 0, 0);

        // SHIFT count 2, stall in DONE, then start held across DONE into IDLE
        go(2'b10, 6'd2);
        cyc("shf2_load", 1, 0, M_LD, 0, 0, 2);
        release_start();
        cyc("shf2_s2", 1, 0, M_SHF, 0, 1, 2);
        cyc("shf2_s1", 1, 0, M_SHF, 0, 1, 1);
        cyc("shf2_done", 1, 1, M_IDL, 0, 0, 0);
        stall_h = 1'b1;
        cyc("shf2_done_st1", 1, 1, M_IDL, 0, 0, 0);
        cyc("shf2_done_st2", 1, 1, M_IDL, 0, 0, 0);
        stall_h = 1'b0;
        go(2'b00, 6'd1);
        cyc("shf2_idle_noacc", 0, 0, M_IDL, 0, 0, 0);
        cyc("mul1_load", 1, 0, M_LD, 0, 0, 1);
        release_start();
        cyc("mul1_s1", 1, 0, M_MUL, 1, 1, 1);
        cyc("mul1_done", 1, 1, M_IDL, 0, 0, 0);
        cyc("mul1_idle", 0, 0, M_IDL, 0, 0, 0);

        // Stall in IDLE does not block start; stall in LOAD holds
        stall_h = 1'b1;
        go(2'b01, 6'd1);
        cyc("div1_load", 1, 0, M_LD, 0, 0, 1);
        release_start();
        cyc("div1_load_st", 1, 0, M_LD, 0, 0, 1);
        stall_h = 1'b0;
        cyc("div1_s1", 1, 0, M_DIV, 0, 1, 1);
        cyc("div1_fix", 1, 0, M_FIX, 0, 0, 0);
        cyc("div1_done", 1, 1, M_IDL, 0, 0, 0);
        cyc("div1_idle", 0, 0, M_IDL, 0, 0, 0);

        // Full-range count
        go(2'b00, 6'd63);
        cyc("mul63_load", 1, 0, M_LD, 0, 0, 63);
        release_start();
        for (int k = 63; k >= 1; k--) cyc("mul63_step", 1, 0, M_MUL, 1, 1, CNT_W'(k));
        cyc("mul63_done", 1, 1, M_IDL, 0, 0, 0);
        cyc("mul63_idle", 0, 0, M_IDL, 0, 0, 0);

        // Asynchronous reset in STEP of DIV count 8
        go(2'b01, 6'd8);
        cyc("div8_load", 1, 0, M_LD, 0, 0, 8);
        release_start();
        cyc("div8_s8", 1, 0, M_DIV, 0, 1, 8);
        cyc("div8_s7", 1, 0, M_DIV, 0, 1, 7);
        #3;
        reset_h = 1'b1;
        #1;
        push("div8_async_rst", 0, 0, M_IDL, 0, 0, 0);
        check();
        cyc("div8_rst_hold", 0, 0, M_IDL, 0, 0, 0);
        reset_h = 1'b0;
        cyc("post_rst_idle", 0, 0, M_IDL, 0, 0, 0);

        // Normal run after reset: MUL count 2 (ext_ena_h only in STEP when pad feature on)
        go(2'b00, 6'd2);
        cyc("mul2_load", 1, 0, M_LD, 0, 0, 2);
        release_start();
        cyc("mul2_s2", 1, 0, M_MUL, 1, 1, 2);
        cyc("mul2_s1", 1, 0, M_MUL, 1, 1, 1);
        cyc("mul2_done", 1, 1, M_IDL, 0, 0, 0);
        cyc("mul2_idle", 0, 0, M_IDL, 0, 0, 0);

        tests_run++;
        assert (sb.size() == 0) else begin
            tests_failed++;
            $error("FAIL sb_leftover: observed %0d entries, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
